// File: rtl/sap_board.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap_board : 8-bit SAP-1 style CPU with a 16x8 program/data RAM      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+

module sap_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [0:15];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module sap_board (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       hlt,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       halted
);
    localparam logic [2:0] c_T0 = 3'd0;
    localparam logic [2:0] c_T1 = 3'd1;
    localparam logic [2:0] c_T2 = 3'd2;
    localparam logic [2:0] c_T3 = 3'd3;
    localparam logic [2:0] c_T4 = 3'd4;

    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_STA = 4'h4;
    localparam logic [3:0] c_OP_LDI = 4'h5;
    localparam logic [3:0] c_OP_JMP = 4'h6;
    localparam logic [3:0] c_OP_JC  = 4'h7;
    localparam logic [3:0] c_OP_JZ  = 4'h8;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    logic [3:0] r_pc;
    logic [3:0] r_mar;
    logic [7:0] r_ir;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_out;
    logic       r_c;
    logic       r_z;
    logic [2:0] r_step;
    logic       r_halted;
    logic       r_out_valid;

    logic [3:0] w_opcode;
    logic [3:0] w_operand;
    logic [7:0] w_rdata;
    logic [7:0] w_b_op;
    logic [8:0] w_sum;
    logic       w_run;
    logic       w_sta_we;
    logic       w_ram_we;
    logic [3:0] w_ram_waddr;
    logic [7:0] w_ram_wdata;

    assign w_opcode  = r_ir[7:4];
    assign w_operand = r_ir[3:0];
    assign w_run     = !hlt && !r_halted;

    // SUB is A + ~B + 1, so the carry out reads as "no borrow"
    assign w_b_op = (w_opcode == c_OP_SUB) ? ~r_b : r_b;
    assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + {8'd0, (w_opcode == c_OP_SUB)};

    // Program port takes priority over an STA landing on the same edge
    assign w_sta_we    = w_run && (r_step == c_T3) && (w_opcode == c_OP_STA);
    assign w_ram_we    = prog_we || w_sta_we;
    assign w_ram_waddr = prog_we ? prog_addr : r_mar;
    assign w_ram_wdata = prog_we ? prog_data : r_a;

    sap_ram rm (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_waddr),
        .wdata (w_ram_wdata),
        .raddr (r_mar),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pc        <= 4'h0;
            r_mar       <= 4'h0;
            r_ir        <= 8'h00;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_out       <= 8'h00;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_step      <= c_T0;
            r_halted    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!w_run) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_step      <= (r_step >= c_T4) ? c_T0 : r_step + 3'd1;
            case (r_step)
                c_T0: r_mar <= r_pc;
                c_T1: begin
                    r_ir <= w_rdata;
                    r_pc <= r_pc + 4'd1;
                end
                c_T2: begin
                    case (w_opcode)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: r_mar <= w_operand;
                        c_OP_LDI: r_a <= {4'h0, w_operand};
                        c_OP_JMP: r_pc <= w_operand;
                        c_OP_JC:  if (r_c) r_pc <= w_operand;
                        c_OP_JZ:  if (r_z) r_pc <= w_operand;
                        c_OP_OUT: begin
                            r_out       <= r_a;
                            r_out_valid <= 1'b1;
                        end
                        c_OP_HLT: r_halted <= 1'b1;
                        default: ;
                    endcase
                end
                c_T3: begin
                    case (w_opcode)
                        c_OP_LDA:           r_a <= w_rdata;
                        c_OP_ADD, c_OP_SUB: r_b <= w_rdata;
                        default: ;
                    endcase
                end
                c_T4: begin
                    if (w_opcode == c_OP_ADD || w_opcode == c_OP_SUB) begin
                        r_a <= w_sum[7:0];
                        r_c <= w_sum[8];
                        r_z <= (w_sum[7:0] == 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_out_valid && !hlt;
    assign halted    = r_halted;
endmodule

`default_nettype wire

// File: tb/tb_sap_board.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sap_board : directed self-checking bench for sap_board          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+

module tb_sap_board;
    logic       clk;
    logic       clr_n;
    logic       hlt;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;

    int total = 0;
    int bad   = 0;

    sap_board dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .hlt       (hlt),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick(1);
        prog_we   = 1'b0;
    endtask

    // Hold reset, wipe RAM through the program port; caller loads and releases
    task automatic prep();
        clr_n = 1'b0;
        hlt   = 1'b0;
        tick(1);
        for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
    endtask

    task automatic load_demo();
        load(4'h0, 8'h1E);
        load(4'h1, 8'h2F);
        load(4'h2, 8'hE0);
        load(4'h3, 8'hF0);
        load(4'hE, 8'h38);
        load(4'hF, 8'h23);
    endtask

    task automatic test_reset();
        prep();
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out got %h want 00", out_data); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got %b want 0", halted); end
        total++; if (dut.r_pc !== 4'h0 || dut.r_step !== 3'd0 || dut.r_a !== 8'h00) begin
            bad++; $display("FAIL reset_regs got pc=%h step=%0d a=%h want 0", dut.r_pc, dut.r_step, dut.r_a);
        end
    endtask

    task automatic test_demo();
        prep();
        load_demo();
        clr_n = 1'b1;
        tick(10);
        total++; if (dut.r_a !== 8'h5B || dut.r_c !== 1'b0 || dut.r_z !== 1'b0) begin
            bad++; $display("FAIL demo_add got a=%h c=%b z=%b want 5b 0 0", dut.r_a, dut.r_c, dut.r_z);
        end
        tick(2);
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            bad++; $display("FAIL demo_pre_out got %h/%b want 00/0", out_data, out_valid);
        end
        tick(1);
        total++; if (out_data !== 8'h5B || out_valid !== 1'b1) begin
            bad++; $display("FAIL demo_out got %h/%b want 5b/1", out_data, out_valid);
        end
        tick(1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL demo_pulse got %b want 0", out_valid); end
        tick(3);
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL demo_early_halt got %b want 0", halted); end
        tick(1);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL demo_halt got %b want 1", halted); end
        tick(10);
        total++; if (dut.r_pc !== 4'h4 || dut.r_step !== 3'd3 || out_data !== 8'h5B || out_valid !== 1'b0) begin
            bad++; $display("FAIL demo_frozen got pc=%h step=%0d out=%h v=%b want 4 3 5b 0",
                            dut.r_pc, dut.r_step, out_data, out_valid);
        end
    endtask

    task automatic test_add_carry();
        prep();
        load(4'h0, 8'h1E);
        load(4'h1, 8'h2F);
        load(4'h2, 8'h75);
        load(4'hE, 8'hFF);
        load(4'hF, 8'h01);
        clr_n = 1'b1;
        tick(10);
        total++; if (dut.r_a !== 8'h00 || dut.r_c !== 1'b1 || dut.r_z !== 1'b1) begin
            bad++; $display("FAIL add_carry got a=%h c=%b z=%b want 00 1 1", dut.r_a, dut.r_c, dut.r_z);
        end
        tick(3);
        total++; if (dut.r_pc !== 4'h5) begin bad++; $display("FAIL jc_taken got pc=%h want 5", dut.r_pc); end
    endtask

    task automatic test_sub();
        prep();
        load(4'h0, 8'h1E);
        load(4'h1, 8'h3F);
        load(4'h2, 8'h1D);
        load(4'h3, 8'h3F);
        load(4'hD, 8'h03);
        load(4'hE, 8'h05);
        load(4'hF, 8'h05);
        clr_n = 1'b1;
        tick(10);
        total++; if (dut.r_a !== 8'h00 || dut.r_c !== 1'b1 || dut.r_z !== 1'b1) begin
            bad++; $display("FAIL sub_equal got a=%h c=%b z=%b want 00 1 1", dut.r_a, dut.r_c, dut.r_z);
        end
        tick(5);
        total++; if (dut.r_a !== 8'h03 || dut.r_c !== 1'b1 || dut.r_z !== 1'b1) begin
            bad++; $display("FAIL lda_keeps_flags got a=%h c=%b z=%b want 03 1 1", dut.r_a, dut.r_c, dut.r_z);
        end
        tick(5);
        total++; if (dut.r_a !== 8'hFE || dut.r_c !== 1'b0 || dut.r_z !== 1'b0) begin
            bad++; $display("FAIL sub_borrow got a=%h c=%b z=%b want fe 0 0", dut.r_a, dut.r_c, dut.r_z);
        end
    endtask

    // collide=1 drives the program port onto mem[F] on the same edge as STA F
    task automatic test_sta(input bit collide);
        logic [7:0] exp_val;
        exp_val = collide ? 8'hAA : 8'h07;
        prep();
        load(4'h0, 8'h57);
        load(4'h1, 8'h4F);
        load(4'h2, 8'h1F);
        load(4'h3, 8'hE0);
        load(4'h4, 8'hF0);
        load(4'hF, 8'h99);
        clr_n = 1'b1;
        tick(8);
        if (collide) begin
            prog_we = 1'b1; prog_addr = 4'hF; prog_data = 8'hAA;
        end
        tick(1);
        prog_we = 1'b0;
        total++; if (dut.rm.mem[15] !== exp_val) begin
            bad++; $display("FAIL sta_mem c=%0d got %h want %h", collide, dut.rm.mem[15], exp_val);
        end
        tick(9);
        total++; if (out_data !== exp_val || out_valid !== 1'b1) begin
            bad++; $display("FAIL sta_out c=%0d got %h/%b want %h/1", collide, out_data, out_valid, exp_val);
        end
        tick(5);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL sta_halt got %b want 1", halted); end
    endtask

    task automatic test_pause();
        prep();
        load(4'h0, 8'h60);
        clr_n = 1'b1;
        tick(7);
        total++; if (dut.r_pc !== 4'h1 || dut.r_step !== 3'd2) begin
            bad++; $display("FAIL pause_pre got pc=%h step=%0d want 1 2", dut.r_pc, dut.r_step);
        end
        hlt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                prog_we = 1'b1; prog_addr = 4'h9; prog_data = 8'h5A;
            end
            tick(1);
            prog_we = 1'b0;
            total++; if (dut.r_pc !== 4'h1 || dut.r_step !== 3'd2 || out_valid !== 1'b0) begin
                bad++; $display("FAIL pause_hold%0d got pc=%h step=%0d want 1 2", i, dut.r_pc, dut.r_step);
            end
        end
        total++; if (dut.rm.mem[9] !== 8'h5A) begin
            bad++; $display("FAIL pause_prog got %h want 5a", dut.rm.mem[9]);
        end
        hlt = 1'b0;
        tick(1);
        total++; if (dut.r_pc !== 4'h0 || dut.r_step !== 3'd3) begin
            bad++; $display("FAIL pause_resume got pc=%h step=%0d want 0 3", dut.r_pc, dut.r_step);
        end
    endtask

    task automatic test_reset_mid();
        prep();
        load_demo();
        clr_n = 1'b1;
        tick(9);
        total++; if (dut.r_b !== 8'h23 || dut.r_a !== 8'h38) begin
            bad++; $display("FAIL mid_pre got a=%h b=%h want 38 23", dut.r_a, dut.r_b);
        end
        clr_n = 1'b0;
        #2;
        total++; if (dut.r_pc !== 4'h0 || dut.r_mar !== 4'h0 || dut.r_ir !== 8'h00 || dut.r_a !== 8'h00 ||
                     dut.r_b !== 8'h00 || dut.r_step !== 3'd0) begin
            bad++; $display("FAIL mid_clear got pc=%h mar=%h ir=%h a=%h b=%h step=%0d want all 0",
                            dut.r_pc, dut.r_mar, dut.r_ir, dut.r_a, dut.r_b, dut.r_step);
        end
        tick(2);
        clr_n = 1'b1;
        tick(13);
        total++; if (out_data !== 8'h5B || out_valid !== 1'b1) begin
            bad++; $display("FAIL mid_rerun got %h/%b want 5b/1", out_data, out_valid);
        end
    endtask

    initial begin
        clr_n     = 1'b0;
        hlt       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 4'h0;
        prog_data = 8'h00;
        #2;
        test_reset();
        test_demo();
        test_add_carry();
        test_sub();
        test_sta(1'b0);
        test_sta(1'b1);
        test_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sap_board.md
SAP_BOARD -- requirements
Module: sap_board

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 clr_n  input  1  asynchronous active-low reset of the whole board except RAM contents.
REQ-003 hlt  input  1  external pause; high freezes all state, low resumes; tie to 0 for free-run.
REQ-004 prog_we  input  1  RAM program-load write enable.
REQ-005 prog_addr  input  4  RAM program-load address.
REQ-006 prog_data  input  8  RAM program-load data.
REQ-007 out_data  output  8  output register contents.
REQ-008 out_valid  output  1  one-cycle pulse when out_data is newly loaded.
REQ-009 halted  output  1  high once an HLT instruction has executed.
REQ-010 Internal RAM instance named rm, 16x8 array named mem, directly preloadable by a bench.

Function
REQ-011 Architecture: 8-bit SAP-1 style; 4-bit PC, 4-bit MAR, 8-bit IR, A, B, OUT registers, carry flag C, zero flag Z, 3-bit step counter T0..T4.
REQ-012 Instruction = {opcode[7:4], operand[3:0]}; every instruction takes exactly 5 cycles (T0..T4), step wraps T4->T0, unused steps idle.
REQ-013 Fetch: T0 MAR<-PC; T1 IR<-mem[MAR], PC<-PC+1 (15 wraps to 0).
REQ-014 NOP 0x0: no action in T2..T4.
REQ-015 LDA 0x1: T2 MAR<-operand; T3 A<-mem[MAR].
REQ-016 ADD 0x2: T2 MAR<-operand; T3 B<-mem[MAR]; T4 A<-(A+B)[7:0], C<-carry out, Z<-(result==0).
REQ-017 SUB 0x3: as ADD but result A+~B+1; C<-carry out of that sum (1 = no borrow); Z as ADD.
REQ-018 STA 0x4: T2 MAR<-operand; T3 mem[MAR]<-A.
REQ-019 LDI 0x5: T2 A<-{4'h0, operand}.
REQ-020 JMP 0x6: T2 PC<-operand.
REQ-021 JC 0x7 / JZ 0x8: T2 PC<-operand if C / Z set, else no action.
REQ-022 OUT 0xE: T2 OUT<-A; out_valid high for the following cycle only.
REQ-023 HLT 0xF: T2 halted<-1; thereafter all registers, flags, step frozen until reset.
REQ-024 Opcodes 0x9..0xD behave as NOP.
REQ-025 Flags change only on ADD/SUB T4.
REQ-026 hlt input high: step, PC and all registers hold; out_valid forced 0; prog port still writes.
REQ-027 prog_we high writes mem[prog_addr]<-prog_data on rising edge, any time; same-edge collision with STA: prog port wins.
REQ-028 RAM read is combinational from MAR.

Reset
REQ-029 clr_n low asynchronously: PC, MAR, IR, A, B, OUT, C, Z, step = 0; halted = 0; out_valid = 0.
REQ-030 RAM contents unaffected by reset; execution starts at address 0 with T0 on first rising edge after clr_n deasserts.
REQ-031 Reset mid-instruction aborts it with no partial RAM write.

Verification
REQ-032 mem[0..3]={0x1E,0x2F,0xE0,0xF0}, mem[E]=0x38, mem[F]=0x23, release reset -> out_data=0x5B after edge 13, out_valid one pulse, halted after edge 18, state frozen after.
REQ-033 ADD 0xFF+0x01 -> A=0x00, C=1, Z=1; following JC 5 -> PC=5.
REQ-034 SUB 0x05-0x05 -> A=0x00, C=1, Z=1; SUB 0x03-0x05 -> A=0xFE, C=0, Z=0.
REQ-035 LDI 7, STA F, LDA F, OUT -> mem[F]=0x07, out_data=0x07.
REQ-036 JMP 0 loop with hlt input pulsed high 3 cycles -> PC/step hold exactly 3 cycles then resume.
REQ-037 Assert clr_n mid-ADD T3 -> all registers 0 immediately; program reruns from address 0.
